// File: rtl/keypad_pkg.sv
// Shared types, sizes and frame-classification helpers for the keypad scanner.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;
    localparam int MAP_W    = NUM_ROWS * NUM_COLS;

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_CHK,
        PRESSED,
        RELEASE_CHK
    } deb_state_t;

    typedef enum logic [1:0] {
        FR_NONE,
        FR_SINGLE,
        FR_MULTI
    } frame_class_t;

    // Number of closed contacts seen in a frame decides NONE / SINGLE / MULTI.
    function automatic frame_class_t classify_map(input logic [MAP_W-1:0] map);
        int ones;
        ones = 0;
        for (int i = 0; i < MAP_W; i++) begin
            if (map[i]) ones++;
        end
        if (ones == 0) return FR_NONE;
        if (ones == 1) return FR_SINGLE;
        return FR_MULTI;
    endfunction

    // Index of the lowest closed contact; only meaningful for a SINGLE frame.
    function automatic logic [CODE_W-1:0] lowest_code(input logic [MAP_W-1:0] map);
        logic [CODE_W-1:0] code;
        code = '0;
        for (int i = MAP_W - 1; i >= 0; i--) begin
            if (map[i]) code = CODE_W'(i);
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin and button-code bundle between the scanner and its surroundings.
//
// There is no valid/ready handshake here: buttons is a held level the consumer
// may decode every cycle, key_valid is an unacknowledged one-cycle strobe that
// coincides with the first cycle buttons shows a newly accepted code, and
// key_down is a plain debounced level.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [NUM_ROWS-1:0] row_n;
    logic [NUM_COLS-1:0] col_n;
    logic [CODE_W-1:0]   buttons;
    logic                key_valid;
    logic                key_down;

    modport master (
        input  row_n,
        output col_n,
        output buttons,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  buttons,
        input  key_valid,
        input  key_down
    );

endinterface

// File: rtl/keypad_matrix_scan.sv
// Column driver, row synchroniser and per-frame contact map with classification.
// frame_valid pulses for one cycle right after the column-3 sample; class and
// code are valid during that cycle only.
module keypad_matrix_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 480
) (
    input  logic                clk_48,
    input  logic                reset_n,
    input  logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_COLS-1:0] col_n,
    output logic                frame_valid,
    output frame_class_t        frame_class,
    output logic [CODE_W-1:0]   frame_code
);

    localparam int DW = $clog2(SCAN_DIV);

    logic [DW-1:0]       dwell;
    logic [1:0]          col_idx;
    logic [NUM_ROWS-1:0] row_meta;
    logic [NUM_ROWS-1:0] row_sync;
    logic [MAP_W-1:0]    map;
    logic [MAP_W-1:0]    hit;
    logic                eval;
    logic                last_dwell;

    assign last_dwell = (dwell == DW'(SCAN_DIV - 1));
    assign col_n      = ~(NUM_COLS'(1) << col_idx);

    // Dwell counter and column index; the column advances on the sample edge.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            dwell   <= '0;
            col_idx <= '0;
        end else if (last_dwell) begin
            dwell   <= '0;
            col_idx <= col_idx + 2'd1;
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Two-flop synchroniser; idle rows read high thanks to the pull-ups.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
        end
    end

    // Map bits for the column currently driven: bit r*4+c for each low row.
    always_comb begin
        hit = '0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            hit[r * NUM_COLS + int'(col_idx)] = ~row_sync[r];
        end
    end

    // Accumulate the frame map; clear it in the evaluation cycle, which always
    // lands well before the next column-0 sample, so scanning never stalls.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            map  <= '0;
            eval <= 1'b0;
        end else begin
            eval <= last_dwell && (col_idx == 2'd3);
            if (eval) begin
                map <= '0;
            end else if (last_dwell) begin
                map <= map | hit;
            end
        end
    end

    assign frame_valid = eval;
    assign frame_class = classify_map(map);
    assign frame_code  = lowest_code(map);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: matrix scan plus a frame-based press/release debouncer.
// buttons holds the last accepted code until the next accepted press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 480,
    parameter int DEBOUNCE_FRAMES = 16,
    parameter int RESET_CODE      = 4
) (
    input  logic              clk_48,
    input  logic              reset_n,
    keypad_scanner_if.master  kp,
    output deb_state_t        dbg_state
);

    localparam int             CW       = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0]  CNT_DONE = CW'(DEBOUNCE_FRAMES);

    logic              frame_valid;
    frame_class_t      frame_class;
    logic [CODE_W-1:0] frame_code;

    deb_state_t        state, state_next;
    logic [CW-1:0]     cnt, cnt_next, cnt_inc;
    logic [CODE_W-1:0] cand, cand_next;
    logic [CODE_W-1:0] buttons_q, accept_code;
    logic              key_valid_q, key_down_q, key_down_next, accept;

    keypad_matrix_scan #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk_48      (clk_48),
        .reset_n     (reset_n),
        .row_n       (kp.row_n),
        .col_n       (kp.col_n),
        .frame_valid (frame_valid),
        .frame_class (frame_class),
        .frame_code  (frame_code)
    );

    // Saturating increment so the frame counter can never wrap.
    assign cnt_inc = (cnt == CNT_DONE) ? cnt : cnt + CW'(1);

    // Debounce next-state logic; it only moves on a frame evaluation.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        cand_next     = cand;
        key_down_next = key_down_q;
        accept        = 1'b0;
        accept_code   = cand;
        if (frame_valid) begin
            case (state)
                RELEASED: begin
                    if (frame_class == FR_SINGLE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            accept        = 1'b1;
                            accept_code   = frame_code;
                            key_down_next = 1'b1;
                            cnt_next      = '0;
                            state_next    = PRESSED;
                        end else begin
                            cand_next  = frame_code;
                            cnt_next   = CW'(1);
                            state_next = PRESS_CHK;
                        end
                    end
                end
                PRESS_CHK: begin
                    if (frame_class != FR_SINGLE) begin
                        cnt_next   = '0;
                        state_next = RELEASED;
                    end else if (frame_code != cand) begin
                        cand_next = frame_code;
                        cnt_next  = CW'(1);
                    end else if (cnt_inc == CNT_DONE) begin
                        accept        = 1'b1;
                        key_down_next = 1'b1;
                        cnt_next      = '0;
                        state_next    = PRESSED;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                PRESSED: begin
                    // Rollover is ignored here: only a full release re-arms.
                    if (frame_class == FR_NONE) begin
                        if (DEBOUNCE_FRAMES == 1) begin
                            key_down_next = 1'b0;
                            cnt_next      = '0;
                            state_next    = RELEASED;
                        end else begin
                            cnt_next   = CW'(1);
                            state_next = RELEASE_CHK;
                        end
                    end
                end
                RELEASE_CHK: begin
                    if (frame_class != FR_NONE) begin
                        cnt_next   = '0;
                        state_next = PRESSED;
                    end else if (cnt_inc == CNT_DONE) begin
                        key_down_next = 1'b0;
                        cnt_next      = '0;
                        state_next    = RELEASED;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = RELEASED;
                end
            endcase
        end
    end

    // Debounce state and output registers; buttons only moves on acceptance.
    always_ff @(posedge clk_48 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RELEASED;
            cnt         <= '0;
            cand        <= '0;
            buttons_q   <= CODE_W'(RESET_CODE);
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cand        <= cand_next;
            key_valid_q <= accept;
            key_down_q  <= key_down_next;
            if (accept) begin
                buttons_q <= accept_code;
            end
        end
    end

    assign kp.buttons   = buttons_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_down  = key_down_q;
    assign dbg_state    = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=8, DEBOUNCE_FRAMES=3
// (one frame = 32 cycles) and a behavioural keypad matrix.
module tb_keypad_scanner;
    import keypad_pkg::*;

    logic        clk_48;
    logic        reset_n;
    logic [15:0] keys;
    logic [3:0]  row_model;
    deb_state_t  dbg_state;
    int          checks;
    int          errors;
    int          kv_count;
    int          base;
    logic [3:0]  col_seq [4];

    keypad_scanner_if kp ();

    keypad_scanner #(
        .SCAN_DIV        (8),
        .DEBOUNCE_FRAMES (3),
        .RESET_CODE      (4)
    ) dut (
        .clk_48    (clk_48),
        .reset_n   (reset_n),
        .kp        (kp),
        .dbg_state (dbg_state)
    );

    // Clock generation
    initial clk_48 = 1'b0;
    always #5 clk_48 = ~clk_48;

    // Keypad model: row r is pulled low while a pressed key in that row sits
    // on the column currently driven low.
    always_comb begin
        row_model = '1;
        for (int r = 0; r < 4; r++) begin
            row_model[r] = ~|(keys[r*4 +: 4] & ~kp.col_n);
        end
    end
    assign kp.row_n = row_model;

    // Count key_valid pulses as they end.
    initial kv_count = 0;
    always @(posedge clk_48) begin
        if (kp.key_valid === 1'b1) kv_count <= kv_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk_48);
    endtask

    // Return at the first negedge after column 0 is driven again.
    task automatic wait_frame_start();
        logic [3:0] prev;
        bit         found;
        prev  = kp.col_n;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge clk_48);
            if (prev == 4'b0111 && kp.col_n == 4'b1110) found = 1'b1;
            prev = kp.col_n;
        end
        if (!found) begin
            checks++;
            errors++;
            $error("FAIL frame_sync: observed no column wrap within 100 cycles, expected one");
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        keys       = '0;
        reset_n    = 1'b0;
        col_seq[0] = 4'b1101;
        col_seq[1] = 4'b1011;
        col_seq[2] = 4'b0111;
        col_seq[3] = 4'b1110;

        // 1: reset values, column stepping, idle frames
        tick(3);
        check("rst_col_n", 32'(kp.col_n), 32'h0E);
        check("rst_buttons", 32'(kp.buttons), 32'd4);
        check("rst_key_valid", 32'(kp.key_valid), 32'd0);
        check("rst_key_down", 32'(kp.key_down), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(RELEASED));
        reset_n = 1'b1;
        tick(7);
        check("col_dwell_end", 32'(kp.col_n), 32'h0E);
        tick(1);
        check("col_step0", 32'(kp.col_n), 32'(col_seq[0]));
        for (int i = 1; i < 4; i++) begin
            tick(8);
            check("col_step", 32'(kp.col_n), 32'(col_seq[i]));
        end
        tick(288);
        check("idle_no_pulse", 32'(kv_count), 32'd0);
        check("idle_buttons", 32'(kp.buttons), 32'd4);

        // 2: press key (2,1) = code 9, then release
        wait_frame_start();
        keys = 16'h0200;
        base = kv_count;
        tick(96);
        check("k9_pre_valid", 32'(kp.key_valid), 32'd0);
        check("k9_pre_down", 32'(kp.key_down), 32'd0);
        tick(1);
        check("k9_valid", 32'(kp.key_valid), 32'd1);
        check("k9_buttons", 32'(kp.buttons), 32'd9);
        check("k9_down", 32'(kp.key_down), 32'd1);
        check("k9_state", 32'(dbg_state), 32'(PRESSED));
        tick(1);
        check("k9_valid_drop", 32'(kp.key_valid), 32'd0);
        check("k9_one_pulse", 32'(kv_count - base), 32'd1);
        wait_frame_start();
        keys = '0;
        tick(96);
        check("k9_rel_pre_down", 32'(kp.key_down), 32'd1);
        check("k9_rel_pre_state", 32'(dbg_state), 32'(RELEASE_CHK));
        tick(1);
        check("k9_rel_down", 32'(kp.key_down), 32'd0);
        check("k9_rel_buttons", 32'(kp.buttons), 32'd9);
        check("k9_rel_state", 32'(dbg_state), 32'(RELEASED));

        // 3: key (1,2) = code 6 bouncing every 20 cycles, then steady
        wait_frame_start();
        base = kv_count;
        for (int i = 0; i < 150; i++) begin
            keys = (((i / 20) % 2) == 0) ? 16'h0040 : 16'h0000;
            tick(1);
        end
        check("bounce_no_pulse", 32'(kv_count - base), 32'd0);
        keys = 16'h0040;
        tick(106);
        check("k6_pre_valid", 32'(kp.key_valid), 32'd0);
        tick(1);
        check("k6_valid", 32'(kp.key_valid), 32'd1);
        check("k6_buttons", 32'(kp.buttons), 32'd6);
        tick(1);
        check("k6_one_pulse", 32'(kv_count - base), 32'd1);

        // 4: keys 0 and 5 together, then only 5
        keys = '0;
        tick(160);
        wait_frame_start();
        keys = 16'h0021;
        base = kv_count;
        tick(192);
        check("multi_no_pulse", 32'(kv_count - base), 32'd0);
        check("multi_buttons", 32'(kp.buttons), 32'd6);
        check("multi_state", 32'(dbg_state), 32'(RELEASED));
        wait_frame_start();
        keys = 16'h0020;
        tick(96);
        check("k5_pre_valid", 32'(kp.key_valid), 32'd0);
        tick(1);
        check("k5_valid", 32'(kp.key_valid), 32'd1);
        check("k5_buttons", 32'(kp.buttons), 32'd5);

        // 5: hold 12, roll onto 3, drop 12; then full release and press 3
        keys = '0;
        tick(160);
        check("k5_released", 32'(kp.key_down), 32'd0);
        wait_frame_start();
        keys = 16'h1000;
        tick(97);
        check("k12_valid", 32'(kp.key_valid), 32'd1);
        check("k12_buttons", 32'(kp.buttons), 32'd12);
        tick(1);
        base = kv_count;
        keys = 16'h1008;
        tick(96);
        check("roll_state", 32'(dbg_state), 32'(PRESSED));
        keys = 16'h0008;
        tick(128);
        check("roll_no_pulse", 32'(kv_count - base), 32'd0);
        check("roll_buttons", 32'(kp.buttons), 32'd12);
        check("roll_down", 32'(kp.key_down), 32'd1);
        wait_frame_start();
        keys = '0;
        tick(97);
        check("roll_rel_down", 32'(kp.key_down), 32'd0);
        check("roll_rel_buttons", 32'(kp.buttons), 32'd12);
        wait_frame_start();
        keys = 16'h0008;
        tick(96);
        check("k3_pre_valid", 32'(kp.key_valid), 32'd0);
        tick(1);
        check("k3_valid", 32'(kp.key_valid), 32'd1);
        check("k3_buttons", 32'(kp.buttons), 32'd3);

        // 6: reset in the middle of debouncing key 15
        keys = '0;
        tick(160);
        wait_frame_start();
        keys = 16'h8000;
        base = kv_count;
        tick(70);
        check("k15_partial_state", 32'(dbg_state), 32'(PRESS_CHK));
        reset_n = 1'b0;
        #1;
        check("mid_rst_buttons", 32'(kp.buttons), 32'd4);
        check("mid_rst_valid", 32'(kp.key_valid), 32'd0);
        check("mid_rst_down", 32'(kp.key_down), 32'd0);
        check("mid_rst_col_n", 32'(kp.col_n), 32'h0E);
        check("mid_rst_state", 32'(dbg_state), 32'(RELEASED));
        tick(3);
        reset_n = 1'b1;
        tick(96);
        check("k15_pre_valid", 32'(kp.key_valid), 32'd0);
        check("k15_no_early_pulse", 32'(kv_count - base), 32'd0);
        tick(1);
        check("k15_valid", 32'(kp.key_valid), 32'd1);
        check("k15_buttons", 32'(kp.buttons), 32'd15);
        check("k15_down", 32'(kp.key_down), 32'd1);
        tick(2);
        check("k15_one_pulse", 32'(kv_count - base), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
